// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// IMEM_NOP_FILL_EN adds the FILL state that pads a short image with NOP_WORD.
package imem_ctrl_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef IMEM_NOP_FILL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/imem_top.sv
// Instruction memory subsystem: load controller plus a write-on-ce-low SRAM
// with combinational read. IMEM_NOP_FILL_EN is passed through to the controller.
module imem_top #(
  parameter int DEPTH  = imem_ctrl_pkg::DEPTH,
  parameter int ADDR_W = imem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = imem_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              loaded,
  output logic [ADDR_W:0]   words_loaded
);

  logic              sram_ce;
  logic [ADDR_W-1:0] sram_init_addr;
  logic [DATA_W-1:0] sram_init_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  imem_load_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .sram_ce       (sram_ce),
    .sram_init_addr(sram_init_addr),
    .sram_init_data(sram_init_data),
    .sram_addr     (sram_addr),
    .sram_rdata    (sram_rdata),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .loaded        (loaded),
    .words_loaded  (words_loaded)
  );

  always_ff @(posedge clk) begin
    if (!sram_ce) begin
      mem[sram_init_addr] <= sram_init_data;
    end
  end

  assign sram_rdata = mem[sram_addr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Streams a program image into an instruction SRAM, then serves 1-cycle fetches.
// Build option IMEM_NOP_FILL_EN: pad words after an early ld_last with NOP_WORD.
module imem_load_ctrl #(
  parameter int DEPTH  = imem_ctrl_pkg::DEPTH,
  parameter int ADDR_W = imem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = imem_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_init_addr,
  output logic [DATA_W-1:0] sram_init_data,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              loaded,
  output logic [ADDR_W:0]   words_loaded
);
  import imem_ctrl_pkg::state_t;
  import imem_ctrl_pkg::IDLE;
  import imem_ctrl_pkg::LOAD;
  import imem_ctrl_pkg::RUN;
`ifdef IMEM_NOP_FILL_EN
  import imem_ctrl_pkg::FILL;
  import imem_ctrl_pkg::NOP_WORD;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                fetch_valid_reg, fetch_valid_next;
  logic [DATA_W-1:0]   fetch_data_reg, fetch_data_next;
  logic                at_last;

  assign at_last      = (ptr_reg == LAST_ADDR);
  assign fetch_valid  = fetch_valid_reg;
  assign fetch_data   = fetch_data_reg;
  assign words_loaded = count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      count_reg       <= '0;
      fetch_valid_reg <= 1'b0;
      fetch_data_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      count_reg       <= count_next;
      fetch_valid_reg <= fetch_valid_next;
      fetch_data_reg  <= fetch_data_next;
    end
  end

  // Writes are qualified with rst_n so the edge that applies reset never writes.
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    count_next       = count_reg;
    fetch_valid_next = 1'b0;
    fetch_data_next  = fetch_data_reg;
    ld_ready         = 1'b0;
    sram_ce          = 1'b1;
    sram_init_addr   = '0;
    sram_init_data   = '0;
    sram_addr        = '0;
    loaded           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          ptr_next   = '0;
          count_next = '0;
        end
      end

      LOAD: begin
        ld_ready = rst_n;
        if (ld_valid && rst_n) begin
          sram_ce        = 1'b0;
          sram_init_addr = ptr_reg;
          sram_init_data = ld_data;
          ptr_next       = ptr_reg + 1'b1;
          count_next     = count_reg + 1'b1;
          if (at_last) begin
            state_next = RUN;
          end else if (ld_last) begin
`ifdef IMEM_NOP_FILL_EN
            state_next = FILL;
`else
            state_next = RUN;
`endif
          end
        end
      end

`ifdef IMEM_NOP_FILL_EN
      FILL: begin
        if (rst_n) begin
          sram_ce        = 1'b0;
          sram_init_addr = ptr_reg;
          sram_init_data = DATA_W'(NOP_WORD);
        end
        ptr_next = ptr_reg + 1'b1;
        if (at_last) begin
          state_next = RUN;
        end
      end
`endif

      RUN: begin
        loaded    = 1'b1;
        sram_addr = fetch_addr;
        if (start) begin
          state_next = LOAD;
          ptr_next   = '0;
          count_next = '0;
        end else if (fetch_req) begin
          fetch_valid_next = 1'b1;
          fetch_data_next  = sram_rdata;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
